// File: rtl/fpu_pkg.sv
// Shared floating-point definitions for the sequential divider.
//   float_t : IEEE-754 single-precision field view (sign / exp / frac)
//   BIAS    : exponent bias (127)
//   EXP_MAX : all-ones exponent used for infinity (255)
//   state_e : divider control FSM states
package fpu_pkg;

  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } float_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/fdiv_round.sv
// Combinational normalize / round / exception stage of the divider.
// Ports:
//   sign    : result sign
//   exp_in  : biased exponent e1-e2+BIAS before normalization (10-bit signed)
//   q       : raw quotient bits, MSB weight 2^0 of m1/m2
//   rem_nz  : final partial remainder is non-zero
//   x1_zero : dividend flushed to zero
//   x2_zero : divisor flushed to zero
//   y       : packed single-precision result
//   ovf     : overflow or divide-by-zero
//   udf     : underflow to zero
module fdiv_round
  import fpu_pkg::*;
#(
  parameter int Q_W = 26
) (
  input  logic              sign,
  input  logic signed [9:0] exp_in,
  input  logic [Q_W-1:0]    q,
  input  logic              rem_nz,
  input  logic              x1_zero,
  input  logic              x2_zero,
  output logic [31:0]       y,
  output logic              ovf,
  output logic              udf
);

  localparam logic signed [9:0] EXP_OVF  = 10'(EXP_MAX);
  // Bits below the guard position after normalization feed the sticky bit.
  localparam logic [Q_W-1:0]    LOW_MASK = {Q_W{1'b1}} >> 25;

  function automatic logic [24:0] round_rne(input logic [23:0] sig,
                                            input logic        guard,
                                            input logic        sticky);
    return {1'b0, sig} + 25'(guard & (sticky | sig[0]));
  endfunction

  logic [Q_W-1:0]    q_n;
  logic [23:0]       sig;
  logic              guard;
  logic              sticky;
  logic [24:0]       sig_r;
  logic signed [9:0] exp_n;
  logic signed [9:0] exp_r;
  float_t            res;

  always_comb begin
    // m1/m2 lies in (0.5, 2): a clear MSB means one left shift normalizes.
    q_n    = q[Q_W-1] ? q : (q << 1);
    sig    = q_n[Q_W-1 -: 24];
    guard  = q_n[Q_W-25];
    sticky = (|(q_n & LOW_MASK)) | rem_nz;
    sig_r  = round_rne(sig, guard, sticky);
    exp_n  = q[Q_W-1] ? exp_in : (exp_in - 10'sd1);
    // A rounding carry leaves sig_r = 2^24 whose low 23 bits are already zero.
    exp_r  = exp_n + (sig_r[24] ? 10'sd1 : 10'sd0);

    res  = '{sign: sign, exp: 8'd0, frac: 23'd0};
    ovf  = 1'b0;
    udf  = 1'b0;
    if (x2_zero) begin
      res.exp = 8'(EXP_MAX);
      ovf     = 1'b1;
    end else if (x1_zero) begin
      res.exp = 8'd0;
    end else if (exp_r >= EXP_OVF) begin
      res.exp = 8'(EXP_MAX);
      ovf     = 1'b1;
    end else if (exp_r <= 10'sd0) begin
      udf     = 1'b1;
    end else begin
      res.exp  = exp_r[7:0];
      res.frac = sig_r[22:0];
    end
    y = res;
  end

endmodule

// File: rtl/fdiv_seq.sv
// Sequential single-precision divider: y = x1 / x2.
// Restoring division of the 24-bit significands, one quotient bit per cycle,
// followed by a normalize/round cycle and a one-cycle result pulse.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   x1, x2   : dividend / divisor, captured when start is seen in IDLE
//   start    : request, only honoured while ready=1
//   ready    : unit idle
//   y        : quotient, held until the next result
//   valid    : one-cycle pulse when y/ovf/udf are new
//   ovf, udf : overflow (or x2 zero) / underflow flags
module fdiv_seq
  import fpu_pkg::*;
#(
  parameter int DIV_ITERS = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic        start,
  output logic        ready,
  output logic [31:0] y,
  output logic        valid,
  output logic        ovf,
  output logic        udf
);

  localparam int               CNT_W    = $clog2(DIV_ITERS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITERS - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DIV_ITERS-1:0] quo_q, quo_d;
  logic [25:0]          rem_q, rem_d;
  logic [23:0]          dvs_q, dvs_d;
  logic                 sign_q, sign_d;
  logic signed [9:0]    exp_q, exp_d;
  logic                 x1z_q, x1z_d;
  logic                 x2z_q, x2z_d;
  logic [31:0]          y_q, y_d;
  logic                 ovf_q, ovf_d;
  logic                 udf_q, udf_d;

  float_t               f1, f2;
  logic                 rem_ge;
  logic [25:0]          rem_sub;
  logic                 rem_nz;
  logic [31:0]          rnd_y;
  logic                 rnd_ovf, rnd_udf;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = DIV;
      DIV:     if (cnt_q == CNT_LAST) state_d = NORM;
      NORM:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    ready = (state_q == IDLE);
    valid = (state_q == DONE);
  end

  // Capture, divide step and result latch
  always_comb begin
    f1      = float_t'(x1);
    f2      = float_t'(x2);
    rem_ge  = (rem_q >= {2'b00, dvs_q});
    rem_sub = rem_q - {2'b00, dvs_q};
    rem_nz  = |rem_q;

    cnt_d  = cnt_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    sign_d = sign_q;
    exp_d  = exp_q;
    x1z_d  = x1z_q;
    x2z_d  = x2z_q;
    y_d    = y_q;
    ovf_d  = ovf_q;
    udf_d  = udf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          sign_d = f1.sign ^ f2.sign;
          exp_d  = $signed({2'b00, f1.exp}) - $signed({2'b00, f2.exp})
                   + $signed(10'(BIAS));
          rem_d  = {2'b00, 1'b1, f1.frac};
          dvs_d  = {1'b1, f2.frac};
          x1z_d  = (f1.exp == 8'd0);
          x2z_d  = (f2.exp == 8'd0);
          cnt_d  = '0;
          quo_d  = '0;
        end
      end
      DIV: begin
        // Partial remainder stays below 2*divisor < 2^25 before the shift.
        rem_d = {(rem_ge ? rem_sub[24:0] : rem_q[24:0]), 1'b0};
        quo_d = {quo_q[DIV_ITERS-2:0], rem_ge};
        cnt_d = cnt_q + 1'b1;
      end
      NORM: begin
        y_d   = rnd_y;
        ovf_d = rnd_ovf;
        udf_d = rnd_udf;
        cnt_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      y_q   <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      y_q   <= y_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    quo_q  <= quo_d;
    rem_q  <= rem_d;
    dvs_q  <= dvs_d;
    sign_q <= sign_d;
    exp_q  <= exp_d;
    x1z_q  <= x1z_d;
    x2z_q  <= x2z_d;
  end

  fdiv_round #(
    .Q_W (DIV_ITERS)
  ) u_round (
    .sign    (sign_q),
    .exp_in  (exp_q),
    .q       (quo_q),
    .rem_nz  (rem_nz),
    .x1_zero (x1z_q),
    .x2_zero (x2z_q),
    .y       (rnd_y),
    .ovf     (rnd_ovf),
    .udf     (rnd_udf)
  );

  assign y   = y_q;
  assign ovf = ovf_q;
  assign udf = udf_q;

endmodule
